// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared types and opcode constants for the immediate-generation
// stage (imm_type_e format enum, RV32I/RV64I major opcodes, shift funct3 codes).
package imm_gen_pkg;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_type_e;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SRX = 3'b101;

endpackage

// File: rtl/imm_gen_if.sv
// imm_gen_if: valid/ready bus around the immediate-generation stage.
//   in_valid/in_ready/in_inst/in_pc      : fetch -> stage
//   out_valid/out_ready/out_imm/out_type/out_target/out_pc/out_illegal
//                                        : stage -> execute
// modport slave is the stage, modport master is its surroundings.
interface imm_gen_if #(
   parameter int XLEN = 32
);
   import imm_gen_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic [XLEN-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_imm;
   imm_type_e       out_type;
   logic [XLEN-1:0] out_target;
   logic [XLEN-1:0] out_pc;
   logic            out_illegal;

   modport master (
      output in_valid, in_inst, in_pc, out_ready,
      input  in_ready, out_valid, out_imm, out_type, out_target, out_pc, out_illegal
   );

   modport slave (
      input  in_valid, in_inst, in_pc, out_ready,
      output in_ready, out_valid, out_imm, out_type, out_target, out_pc, out_illegal
   );

endinterface

// File: rtl/imm_decode.sv
// imm_decode: combinational immediate decoder.
//   inst    in  32    instruction word
//   pc      in  XLEN  instruction address
//   imm     out XLEN  sign-extended immediate (B/J halfword units if HALF_SCALED)
//   itype   out 3     immediate format
//   target  out XLEN  pc + byte offset for B, J, AUIPC; 0 otherwise
//   illegal out 1     opcode not supported
module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int HALF_SCALED = 0
) (
   input  logic [31:0]     inst,
   input  logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] imm,
   output imm_type_e       itype,
   output logic [XLEN-1:0] target,
   output logic            illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic signed [XLEN-1:0] i_imm, s_imm, b_imm, j_imm, u_imm;
   logic [XLEN-1:0] shamt;

   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];

   assign i_imm = XLEN'($signed(inst[31:20]));
   assign s_imm = XLEN'($signed({inst[31:25], inst[11:7]}));
   assign b_imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
   assign j_imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
   assign u_imm = XLEN'($signed({inst[31:12], 12'b0}));
   // RV64 shifts carry a 6-bit shamt; funct7 bits above it are not part of the immediate
   assign shamt = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);

   always_comb begin
      imm     = '0;
      itype   = IMM_NONE;
      target  = '0;
      illegal = 1'b0;
      case (opcode)
         OPC_OP_IMM: begin
            itype = IMM_I;
            imm   = (funct3 == F3_SLL || funct3 == F3_SRX) ? shamt : i_imm;
         end
         OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
            itype = IMM_I;
            imm   = i_imm;
         end
         OPC_STORE: begin
            itype = IMM_S;
            imm   = s_imm;
         end
         OPC_BRANCH: begin
            itype  = IMM_B;
            imm    = (HALF_SCALED != 0) ? (b_imm >>> 1) : b_imm;
            target = pc + b_imm;
         end
         OPC_JAL: begin
            itype  = IMM_J;
            imm    = (HALF_SCALED != 0) ? (j_imm >>> 1) : j_imm;
            target = pc + j_imm;
         end
         OPC_LUI: begin
            itype = IMM_U;
            imm   = u_imm;
         end
         OPC_AUIPC: begin
            itype  = IMM_U;
            imm    = u_imm;
            target = pc + u_imm;
         end
         OPC_OP: ;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: decode stage producing immediates into a DEPTH-entry FIFO.
//   clk, rst     clock and synchronous active-high reset
//   flush        drop all buffered entries and the same-cycle input
//   bus          imm_gen_if slave: in_* from fetch, out_* to execute
//   illegal_cnt  saturating count of accepted illegal instructions
module imm_gen_stage
   import imm_gen_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int DEPTH       = 2,
   parameter int HALF_SCALED = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   imm_gen_if.slave    bus,
   output logic [15:0] illegal_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] dec_imm, dec_target;
   imm_type_e       dec_type;
   logic            dec_illegal;

   imm_decode #(
      .XLEN        (XLEN),
      .HALF_SCALED (HALF_SCALED)
   ) u_dec (
      .inst    (bus.in_inst),
      .pc      (bus.in_pc),
      .imm     (dec_imm),
      .itype   (dec_type),
      .target  (dec_target),
      .illegal (dec_illegal)
   );

   logic [XLEN-1:0] mem_imm    [DEPTH];
   logic [XLEN-1:0] mem_target [DEPTH];
   logic [XLEN-1:0] mem_pc     [DEPTH];
   imm_type_e       mem_type   [DEPTH];
   logic            mem_ill    [DEPTH];

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          full, vld, push, pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full         = (count == CW'(DEPTH));
   assign vld          = (count != '0);
   // in_ready ignores pop so a full FIFO never accepts, even while draining
   assign bus.in_ready = !full && !rst;
   assign push         = bus.in_valid && bus.in_ready && !flush;
   assign pop          = vld && bus.out_ready;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_imm[wr_ptr]    <= dec_imm;
         mem_target[wr_ptr] <= dec_target;
         mem_pc[wr_ptr]     <= bus.in_pc;
         mem_type[wr_ptr]   <= dec_type;
         mem_ill[wr_ptr]    <= dec_illegal;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         illegal_cnt <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
         if (push && dec_illegal && illegal_cnt != '1)
            illegal_cnt <= illegal_cnt + 16'd1;
      end
   end

   assign bus.out_valid   = vld;
   assign bus.out_imm     = vld ? mem_imm[rd_ptr]    : '0;
   assign bus.out_target  = vld ? mem_target[rd_ptr] : '0;
   assign bus.out_pc      = vld ? mem_pc[rd_ptr]     : '0;
   assign bus.out_type    = vld ? mem_type[rd_ptr]   : IMM_NONE;
   assign bus.out_illegal = vld ? mem_ill[rd_ptr]    : 1'b0;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed vectors for imm_gen_stage.
// m: XLEN=32 DEPTH=2 byte offsets; h: HALF_SCALED=1; w: XLEN=64.
module tb_imm_gen_stage;
   import imm_gen_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   logic [15:0] cnt_m, cnt_h, cnt_w;
   int unsigned n_vec = 0;
   int unsigned n_miss = 0;

   always #5 clk = ~clk;

   imm_gen_if #(.XLEN(32)) m ();
   imm_gen_if #(.XLEN(32)) h ();
   imm_gen_if #(.XLEN(64)) w ();

   imm_gen_stage #(.XLEN(32), .DEPTH(2), .HALF_SCALED(0)) dut (
      .clk(clk), .rst(rst), .flush(flush), .bus(m), .illegal_cnt(cnt_m));
   imm_gen_stage #(.XLEN(32), .DEPTH(2), .HALF_SCALED(1)) dut_h (
      .clk(clk), .rst(rst), .flush(1'b0), .bus(h), .illegal_cnt(cnt_h));
   imm_gen_stage #(.XLEN(64), .DEPTH(2), .HALF_SCALED(0)) dut_w (
      .clk(clk), .rst(rst), .flush(1'b0), .bus(w), .illegal_cnt(cnt_w));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // single-cycle push into all three DUTs; returns at the negedge after acceptance
   task automatic xfer(input logic [31:0] inst, input logic [63:0] pc);
      @(negedge clk);
      m.in_valid = 1'b1; m.in_inst = inst; m.in_pc = pc[31:0];
      h.in_valid = 1'b1; h.in_inst = inst; h.in_pc = pc[31:0];
      w.in_valid = 1'b1; w.in_inst = inst; w.in_pc = pc;
      @(negedge clk);
      m.in_valid = 1'b0; h.in_valid = 1'b0; w.in_valid = 1'b0;
   endtask

   initial begin
      m.in_valid = 1'b0; m.in_inst = '0; m.in_pc = '0; m.out_ready = 1'b1;
      h.in_valid = 1'b0; h.in_inst = '0; h.in_pc = '0; h.out_ready = 1'b1;
      w.in_valid = 1'b0; w.in_inst = '0; w.in_pc = '0; w.out_ready = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_in_ready", 64'(m.in_ready), 64'd0);
      check("rst_out_valid", 64'(m.out_valid), 64'd0);
      check("rst_out_imm", 64'(m.out_imm), 64'd0);
      check("rst_cnt", 64'(cnt_m), 64'd0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 64'(m.in_ready), 64'd1);

      xfer(32'hFFF00093, 64'h0);
      check("addi_valid", 64'(m.out_valid), 64'd1);
      check("addi_imm", 64'(m.out_imm), 64'hFFFF_FFFF);
      check("addi_type", 64'(m.out_type), 64'(IMM_I));
      check("addi_ill", 64'(m.out_illegal), 64'd0);
      check("addi_tgt", 64'(m.out_target), 64'd0);

      xfer(32'hFE000EE3, 64'h100);
      check("beq_imm", 64'(m.out_imm), 64'hFFFF_FFFC);
      check("beq_tgt", 64'(m.out_target), 64'hFC);
      check("beq_type", 64'(m.out_type), 64'(IMM_B));
      check("beq_pc", 64'(m.out_pc), 64'h100);
      check("beq_h_imm", 64'(h.out_imm), 64'hFFFF_FFFE);
      check("beq_h_tgt", 64'(h.out_target), 64'hFC);

      xfer(32'h123450B7, 64'h40);
      check("lui_imm", 64'(m.out_imm), 64'h1234_5000);
      check("lui_type", 64'(m.out_type), 64'(IMM_U));
      check("lui_tgt", 64'(m.out_target), 64'd0);

      xfer(32'h800000B7, 64'h0);
      check("lui64_imm", w.out_imm, 64'hFFFF_FFFF_8000_0000);

      xfer(32'h4030D093, 64'h0);
      check("srai_imm", 64'(m.out_imm), 64'd3);
      check("srai_type", 64'(m.out_type), 64'(IMM_I));

      xfer(32'h00001117, 64'h200);
      check("auipc_imm", 64'(m.out_imm), 64'h1000);
      check("auipc_tgt", 64'(m.out_target), 64'h1200);

      xfer(32'hFE112E23, 64'h300);
      check("sw_imm", 64'(m.out_imm), 64'hFFFF_FFFC);
      check("sw_type", 64'(m.out_type), 64'(IMM_S));
      check("sw_tgt", 64'(m.out_target), 64'd0);

      xfer(32'h0080006F, 64'h1000);
      check("jal_imm", 64'(m.out_imm), 64'd8);
      check("jal_tgt", 64'(m.out_target), 64'h1008);
      check("jal_type", 64'(m.out_type), 64'(IMM_J));
      check("jal_h_imm", 64'(h.out_imm), 64'd4);

      xfer(32'h002081B3, 64'h0);
      check("add_type", 64'(m.out_type), 64'(IMM_NONE));
      check("add_ill", 64'(m.out_illegal), 64'd0);

      xfer(32'h0000007F, 64'h0);
      check("ill_flag", 64'(m.out_illegal), 64'd1);
      check("ill_imm", 64'(m.out_imm), 64'd0);
      check("ill_cnt", 64'(cnt_m), 64'd1);
      @(negedge clk);
      check("empty_after_pop", 64'(m.out_valid), 64'd0);

      // back-pressure: three pushes into DEPTH=2
      m.out_ready = 1'b0;
      m.in_valid = 1'b1; m.in_inst = 32'h00100093; m.in_pc = 32'h10;
      @(negedge clk);
      m.in_inst = 32'h00200093; m.in_pc = 32'h14;
      @(negedge clk);
      check("full_in_ready", 64'(m.in_ready), 64'd0);
      m.in_inst = 32'h00300093; m.in_pc = 32'h18;
      @(negedge clk);
      check("full_hold_ready", 64'(m.in_ready), 64'd0);
      check("fifo_head0", 64'(m.out_imm), 64'd1);
      m.out_ready = 1'b1;
      @(negedge clk);
      check("fifo_head1", 64'(m.out_imm), 64'd2);
      check("ready_after_pop", 64'(m.in_ready), 64'd1);
      @(negedge clk);
      m.in_valid = 1'b0;
      check("fifo_head2", 64'(m.out_imm), 64'd3);
      check("fifo_pc2", 64'(m.out_pc), 64'h18);
      @(negedge clk);
      check("fifo_drained", 64'(m.out_valid), 64'd0);

      // flush while full, then flush with a push that would be accepted
      m.out_ready = 1'b0;
      m.in_valid = 1'b1; m.in_inst = 32'h00100093;
      repeat (2) @(negedge clk);
      m.in_inst = 32'h0000007F; flush = 1'b1;
      @(negedge clk);
      check("flush_full_valid", 64'(m.out_valid), 64'd0);
      check("flush_full_cnt", 64'(cnt_m), 64'd1);
      @(negedge clk);
      check("flush_push_valid", 64'(m.out_valid), 64'd0);
      check("flush_push_cnt", 64'(cnt_m), 64'd1);
      flush = 1'b0; m.in_valid = 1'b0;

      // reset mid-operation
      m.in_valid = 1'b1; m.in_inst = 32'h00500093; m.in_pc = 32'h44;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_valid", 64'(m.out_valid), 64'd0);
      check("rst_mid_imm", 64'(m.out_imm), 64'd0);
      check("rst_mid_pc", 64'(m.out_pc), 64'd0);
      check("rst_mid_ready", 64'(m.in_ready), 64'd0);
      check("rst_mid_cnt", 64'(cnt_m), 64'd0);
      rst = 1'b0; m.in_valid = 1'b0;

      // counter saturation
      m.out_ready = 1'b1;
      @(negedge clk);
      m.in_valid = 1'b1; m.in_inst = 32'h0000007F; m.in_pc = '0;
      repeat (65534) @(posedge clk);
      @(negedge clk);
      check("cnt_fffe", 64'(cnt_m), 64'hFFFE);
      @(negedge clk);
      check("cnt_ffff", 64'(cnt_m), 64'hFFFF);
      @(negedge clk);
      check("cnt_sat", 64'(cnt_m), 64'hFFFF);
      m.in_valid = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Pipelined, parametrised immediate-generation stage for the RISC-V decode path. Decodes the immediate of every RV32I/RV64I format (I, S, B, U, J, plus shift-amount), flags unsupported opcodes, and precomputes the PC-relative target. Results are pushed through a DEPTH-entry valid/ready output FIFO so fetch and execute can stall independently. It sits between instruction fetch and the register-read/execute stage.

## Interface
- XLEN, 32: datapath width, 32 or 64; all immediates sign-extended to XLEN.
- DEPTH, 2: output FIFO entries, power of two, ≥1.
- HALF_SCALED, 0: 1 = B/J `out_imm` emitted in halfword units (bit 0 dropped, arithmetic right-shifted by 1); 0 = byte offset.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all buffered entries and same-cycle input.
- in_valid  in  1  `in_inst`/`in_pc` valid.
- in_ready  out  1  stage can accept.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- out_imm  out  XLEN  decoded immediate.
- out_type  out  3  immediate format (package enum).
- out_target  out  XLEN  PC-relative target.
- out_pc  out  XLEN  pass-through PC.
- out_illegal  out  1  opcode unsupported.
- illegal_cnt  out  16  saturating count of accepted illegal instructions.

## Operation
- Opcode map (inst[6:0]):
  - I: 0010011, 0000011, 1100111, 1110011.
  - S: 0100011. B: 1100011. J: 1101111.
  - U: 0110111, 0010111.
  - NONE, legal: 0110011, imm 0.
  - Other: NONE, illegal, imm 0.
- Formats: I = sext(inst[31:20]); S = sext({inst[31:25],inst[11:7]}); B = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}); J = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}); U = sext({inst[31:12],12'b0}).
- Shifts: opcode 0010011 with funct3 001/101 → imm = zero-extended shamt (inst[24:20] for XLEN=32, inst[25:20] for XLEN=64); funct7 bits excluded.
- HALF_SCALED applies to B and J only.
- `out_target` = in_pc + byte-offset immediate (unaffected by HALF_SCALED) for B, J, AUIPC; 0 otherwise. Addition wraps modulo 2^XLEN.
- Push: decode computed combinationally from `in_*`; entry written when in_valid & in_ready & !flush.
- Pop: head removed when out_valid & out_ready.
- in_ready = !full & !rst. No same-cycle push-while-full, even with a pop.
- Simultaneous push and pop when not full: occupancy unchanged, order preserved.
- flush: occupancy → 0 next cycle; same-cycle push dropped and not counted.
- illegal_cnt: +1 per accepted illegal entry; saturates at 0xFFFF; not decremented by flush.
- out_imm/out_type/out_target/out_pc/out_illegal are driven 0 whenever out_valid=0.

## Timing
- Reset values: out_valid 0, all out_* 0, illegal_cnt 0, FIFO empty; in_ready 0 while rst=1, 1 in the first cycle after rst deasserts.
- rst mid-operation discards all entries; takes priority over flush, push and pop.
- Latency: accepted at edge N → out_valid high from cycle N+1. Throughput one per cycle while out_ready=1.
- Full: after DEPTH accepts without a pop, in_ready is low the next cycle; it rises the cycle after the first pop.
- Empty: out_valid falls the cycle after the last pop when there is no push.
- Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.

## Structure
- Package imm_gen_pkg: imm_type_e (NONE=0, I=1, S=2, B=3, U=4, J=5), opcode localparams, funct3 shift codes.
- Sub-module imm_decode: combinational (inst, pc) → (imm, type, target, illegal), parametrised by XLEN and HALF_SCALED.
- Top module holds the FIFO, pointers, occupancy, counter and handshake.

## Test plan
- addi 0xFFF00093, pc 0x0: next cycle out_imm 0xFFFFFFFF, type I, illegal 0, target 0.
- beq 0xFE000EE3, pc 0x100: HALF_SCALED=0 → imm 0xFFFFFFFC, target 0xFC. HALF_SCALED=1 → imm 0xFFFFFFFE, target 0xFC.
- lui 0x123450B7 → imm 0x12345000, type U. XLEN=64 with lui 0x800000B7 → 0xFFFFFFFF80000000. srai 0x4030D093 → imm 3.
- DEPTH=2, out_ready=0, three back-to-back pushes: two accepted, in_ready low; after out_ready=1, outputs appear in push order and the third entry is accepted.
- Inst 0x0000007F → illegal 1, imm 0, illegal_cnt 1. Preload illegal_cnt to 0xFFFF via 65535 illegal pushes, then one more → count stays 0xFFFF.
- FIFO full, flush with a simultaneous valid push: out_valid 0 next cycle, push lost, illegal_cnt unchanged. Repeat with rst instead: all outputs 0.
